rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Sits between the HPS download interface and the game core.
- Takes the serial ROM byte stream and routes each byte to one of four ROM regions as a region-relative address with a one-hot write strobe.
- Checks the loaded image size and generates the core's power-on/reload reset, held for a programmable time after the download ends.
- Replaces the ad-hoc "released after first download" reset in the top level.

Parameters:
- ADDR_W, 17: width of region-relative output address.
- R0_END, 'h0C000: exclusive end of region 0 (program ROM). Region 0 starts at 0.
- R1_END, 'h0E000: exclusive end of region 1 (sound ROM).
- R2_END, 'h14000: exclusive end of region 2 (tile/sprite ROM).
- R3_END, 'h15000: exclusive end of region 3 (PROM/bg map). Also the expected total image size.
- RST_HOLD, 1024: number of clk_sys cycles core_reset stays high after the download ends. Must be ≥1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- dl_active  in  1  download in progress (level).
- dl_wr  in  1  byte-valid strobe, 1 cycle per byte.
- dl_addr  in  25  absolute byte address.
- dl_data  in  8  byte.
- rom_wr  out  4  one-hot region write strobe.
- rom_addr  out  ADDR_W  address relative to the region start.
- rom_data  out  8  byte.
- core_reset  out  1  active-high reset to the game core.
- load_ok  out  1  last download completed with the correct size and no errors.
- load_err  out  1  last download had an out-of-range write or a size mismatch.
- byte_count  out  25  bytes accepted in the current or last download.

Behaviour:
- Reset values: rom_wr=0, rom_addr=0, rom_data=0, core_reset=1, load_ok=0, load_err=0, byte_count=0. FSM goes to WAIT.
- FSM states and transitions:
  - WAIT: no valid image yet; core_reset=1. Goes to LOAD on dl_active=1.
  - LOAD: core_reset=1. On the cycle dl_active falls, evaluate the size check and go to HOLD.
  - HOLD: core_reset=1; hold counter counts RST_HOLD cycles. Goes to RUN if load_ok, otherwise to WAIT.
  - RUN: core_reset=0. Goes to LOAD on dl_active=1.
- Entry into LOAD (from any state, including HOLD): clear byte_count, load_ok and load_err. Restart the hold counter on the next exit.
- Routing: registered, latency 1 cycle.
  - If in LOAD and dl_wr=1, the region is chosen by the first match: addr<R0_END → 0, <R1_END → 1, <R2_END → 2, <R3_END → 3.
  - On the next cycle: rom_wr[region]=1 for exactly 1 cycle, rom_addr = dl_addr − region start (truncated to ADDR_W), rom_data = dl_data, and byte_count increments.
  - If addr ≥ R3_END: no strobe, byte_count unchanged, and a sticky error flag is set.
- dl_wr while not in LOAD (including the same cycle dl_active first rises, which is the WAIT/RUN→LOAD edge): ignored. No strobe, no count.
- A dl_wr in the same cycle dl_active falls is accepted, and the size check includes it. The check is evaluated one cycle later, in HOLD's first cycle, so the pipelined increment is visible to it.
- Size check: load_ok=1 iff byte_count==R3_END and the sticky error flag is clear; otherwise load_err=1. Both flags are set on HOLD entry and stay valid until the next LOAD.
- Duplicate addresses are written again and counted again, so they cause a size mismatch.
- core_reset is registered and deasserts on the first RUN cycle, i.e. RST_HOLD+1 cycles after the dl_active falling edge.
- Async reset mid-download: everything returns to reset values, and any strobe in flight is killed. A download still active after reset release is ignored until dl_active is seen low, then high again.
- The 25-bit byte_count saturates at all-ones and never wraps.

Test Plan:
- Full image, with R3_END bytes at addresses 0..'h14FFF, then dl_active falls → strobes go to regions 0/1/2/3 with counts 'hC000/'h2000/'h6000/'h1000. Byte at 'h0E000 gives rom_wr=4'b0100, rom_addr=0. Then load_ok=1, load_err=0, and core_reset falls exactly 1025 cycles after the dl_active fall.
- Short image of 'h14FFF bytes → load_err=1, load_ok=0, core_reset stays 1, FSM returns to WAIT.
- Extra write at 'h15000 inside an otherwise complete image → no strobe, byte_count='h15000, load_err=1.
- Reload from RUN: dl_active rises → core_reset=1 on the next cycle and flags are cleared. A dl_wr in that rise cycle produces no strobe.
- Async reset asserted mid-LOAD after 100 bytes, released while dl_active is still high → no strobes until dl_active goes low then high again. byte_count=0 and core_reset=1 throughout.
- dl_wr pulses while in RUN → rom_wr stays 0, byte_count unchanged, core_reset stays 0.

Source files
------------

// File: rtl/rom_loader.sv
// ROM download router: splits the HPS byte stream into four region-relative write ports,
// checks the image size and drives the game core's load/reload reset.
module rom_loader #(
    parameter int ADDR_W   = 17,
    parameter int R0_END   = 'h0C000,
    parameter int R1_END   = 'h0E000,
    parameter int R2_END   = 'h14000,
    parameter int R3_END   = 'h15000,
    parameter int RST_HOLD = 1024
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [24:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic [3:0]        rom_wr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              core_reset,
    output logic              load_ok,
    output logic              load_err,
    output logic [24:0]       byte_count
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [24:0] R0_END_C = 25'(R0_END);
    localparam logic [24:0] R1_END_C = 25'(R1_END);
    localparam logic [24:0] R2_END_C = 25'(R2_END);
    localparam logic [24:0] R3_END_C = 25'(R3_END);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(RST_HOLD - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic                dl_active_q_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                err_r;
    logic                rise_s;
    logic                accept_s;
    logic                load_entry_s;
    logic                check_ok_s;
    logic                in_range_s;
    logic [1:0]          region_s;
    logic [24:0]         base_s;
    logic [ADDR_W-1:0]   rel_addr_s;
    logic [3:0]          rom_wr_r;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic [7:0]          rom_data_r;
    logic                core_reset_r;
    logic                load_ok_r;
    logic                load_err_r;
    logic [24:0]         byte_count_r;

    // The edge detector resets to "high" so a download already running at reset release
    // is not mistaken for a new one until dl_active has been seen low.
    assign rise_s       = dl_active & ~dl_active_q_r;
    assign accept_s     = (state_r == ST_LOAD) & dl_wr;
    assign load_entry_s = (state_next_s == ST_LOAD) & (state_r != ST_LOAD);
    assign check_ok_s   = (byte_count_r == R3_END_C) & ~err_r;
    assign rel_addr_s   = ADDR_W'(dl_addr - base_s);

    assign rom_wr     = rom_wr_r;
    assign rom_addr   = rom_addr_r;
    assign rom_data   = rom_data_r;
    assign core_reset = core_reset_r;
    assign load_ok    = load_ok_r;
    assign load_err   = load_err_r;
    assign byte_count = byte_count_r;

    // Region decode: first matching exclusive end wins.
    always_comb begin
        region_s   = 2'd0;
        base_s     = 25'd0;
        in_range_s = 1'b1;
        if (dl_addr < R0_END_C) begin
            region_s = 2'd0;
            base_s   = 25'd0;
        end else if (dl_addr < R1_END_C) begin
            region_s = 2'd1;
            base_s   = R0_END_C;
        end else if (dl_addr < R2_END_C) begin
            region_s = 2'd2;
            base_s   = R1_END_C;
        end else if (dl_addr < R3_END_C) begin
            region_s = 2'd3;
            base_s   = R2_END_C;
        end else begin
            in_range_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (rise_s) state_next_s = ST_LOAD;
                else        state_next_s = ST_WAIT;
            end
            ST_LOAD: begin
                if (!dl_active) state_next_s = ST_HOLD;
                else            state_next_s = ST_LOAD;
            end
            ST_HOLD: begin
                // byte_count and err_r are frozen in HOLD, so the live check is safe here
                if (rise_s)                         state_next_s = ST_LOAD;
                else if (hold_cnt_r == HOLD_LAST_C) state_next_s = check_ok_s ? ST_RUN : ST_WAIT;
                else                                state_next_s = ST_HOLD;
            end
            ST_RUN: begin
                if (rise_s) state_next_s = ST_LOAD;
                else        state_next_s = ST_RUN;
            end
            default: state_next_s = ST_WAIT;
        endcase
    end

    // State register, download edge detector and hold counter.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r       <= ST_WAIT;
            dl_active_q_r <= 1'b1;
            hold_cnt_r    <= HOLD_W'(0);
        end else begin
            state_r       <= state_next_s;
            dl_active_q_r <= dl_active;
            if (state_r != ST_HOLD) begin
                hold_cnt_r <= HOLD_W'(0);
            end else if (hold_cnt_r != HOLD_LAST_C) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Write routing, byte counting, status flags and the core reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_wr_r     <= 4'b0000;
            rom_addr_r   <= '0;
            rom_data_r   <= 8'd0;
            core_reset_r <= 1'b1;
            load_ok_r    <= 1'b0;
            load_err_r   <= 1'b0;
            byte_count_r <= 25'd0;
            err_r        <= 1'b0;
        end else begin
            rom_wr_r     <= 4'b0000;
            core_reset_r <= (state_next_s != ST_RUN);
            if (load_entry_s) begin
                byte_count_r <= 25'd0;
                err_r        <= 1'b0;
                load_ok_r    <= 1'b0;
                load_err_r   <= 1'b0;
            end else if (accept_s) begin
                if (in_range_s) begin
                    rom_wr_r   <= 4'b0001 << region_s;
                    rom_addr_r <= rel_addr_s;
                    rom_data_r <= dl_data;
                    if (byte_count_r != {25{1'b1}}) byte_count_r <= byte_count_r + 25'd1;
                    else                            byte_count_r <= byte_count_r;
                end else begin
                    err_r <= 1'b1;
                end
            end else if ((state_r == ST_HOLD) && (hold_cnt_r == HOLD_W'(0))) begin
                load_ok_r  <= check_ok_s;
                load_err_r <= ~check_ok_s;
            end else begin
                load_ok_r  <= load_ok_r;
                load_err_r <= load_err_r;
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized directed bench for rom_loader, using scaled-down region sizes so that
// several complete images fit in a short run.
module tb_rom_loader;

    localparam int ADDR_W   = 17;
    localparam int R0_END   = 'h0C0;
    localparam int R1_END   = 'h0E0;
    localparam int R2_END   = 'h140;
    localparam int R3_END   = 'h150;
    localparam int RST_HOLD = 20;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              dl_active;
    logic              dl_wr;
    logic [24:0]       dl_addr;
    logic [7:0]        dl_data;
    logic [3:0]        rom_wr;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              core_reset;
    logic              load_ok;
    logic              load_err;
    logic [24:0]       byte_count;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    bit model_loading = 1'b0;
    bit model_err = 1'b0;
    int hits[4];
    int ends_a[4] = '{R0_END, R1_END, R2_END, R3_END};

    rom_loader #(
        .ADDR_W(ADDR_W), .R0_END(R0_END), .R1_END(R1_END),
        .R2_END(R2_END), .R3_END(R3_END), .RST_HOLD(RST_HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .rom_wr(rom_wr), .rom_addr(rom_addr),
        .rom_data(rom_data), .core_reset(core_reset), .load_ok(load_ok),
        .load_err(load_err), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int region_of(input int a);
        for (int r = 0; r < 4; r++) if (a < ends_a[r]) return r;
        return -1;
    endfunction

    function automatic int region_start(input int r);
        return (r == 0) ? 0 : ends_a[r-1];
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input int a, input logic [7:0] d);
        int r;
        r = region_of(a);
        dl_wr = 1'b1;
        dl_addr = 25'(a);
        dl_data = d;
        tick();
        dl_wr = 1'b0;
        for (int k = 0; k < 4; k++) if (rom_wr[k]) hits[k]++;
        if (model_loading && r >= 0) begin
            model_count++;
            check("rom_wr", 32'(rom_wr), 32'(1) << r);
            check("rom_addr", 32'(rom_addr), 32'(a - region_start(r)));
            check("rom_data", 32'(rom_data), 32'(d));
            if (a == R1_END) begin
                check("r2_first_wr", 32'(rom_wr), 32'(4'b0100));
                check("r2_first_addr", 32'(rom_addr), 32'd0);
            end
        end else begin
            if (model_loading) model_err = 1'b1;
            check("rom_wr_none", 32'(rom_wr), 32'd0);
        end
        check("byte_count", 32'(byte_count), 32'(model_count));
    endtask

    task automatic start_download(input bit wr_in_rise);
        dl_active = 1'b1;
        dl_wr = wr_in_rise;
        dl_addr = 25'd0;
        dl_data = 8'hA5;
        tick();
        dl_wr = 1'b0;
        check("rise_no_strobe", 32'(rom_wr), 32'd0);
        check("rise_core_reset", 32'(core_reset), 32'd1);
        check("rise_load_ok", 32'(load_ok), 32'd0);
        check("rise_load_err", 32'(load_err), 32'd0);
        check("rise_count", 32'(byte_count), 32'd0);
        model_loading = 1'b1;
        model_err = 1'b0;
        model_count = 0;
        for (int k = 0; k < 4; k++) hits[k] = 0;
    endtask

    // Complete shuffled image, optionally missing one address and/or with one extra address;
    // the final byte is written in the cycle dl_active falls.
    task automatic run_download(input int skip_addr, input int extra_addr);
        int q[$];
        int j;
        int t;
        for (int a = 0; a < R3_END; a++) if (a != skip_addr) q.push_back(a);
        for (int i = q.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
        if (extra_addr >= 0) q.insert(q.size() / 2, extra_addr);
        for (int i = 0; i < q.size() - 1; i++) begin
            send_byte(q[i], 8'($urandom));
            if ($urandom_range(3, 0) == 0) tick();
        end
        dl_active = 1'b0;
        send_byte(q[q.size() - 1], 8'($urandom));
        model_loading = 1'b0;
    endtask

    task automatic finish_hold(input string tag);
        int n;
        bit ok;
        ok = (model_count == R3_END) && !model_err;
        n = 1;
        while (core_reset === 1'b1 && n < 3 * RST_HOLD) begin
            tick();
            n++;
        end
        if (ok) begin
            check({tag, "_release_cycles"}, 32'(n), 32'(RST_HOLD + 1));
            check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
        end else begin
            check({tag, "_core_reset_held"}, 32'(core_reset), 32'd1);
        end
        check({tag, "_load_ok"}, 32'(load_ok), 32'(ok));
        check({tag, "_load_err"}, 32'(load_err), 32'(!ok));
        check({tag, "_count"}, 32'(byte_count), 32'(model_count));
    endtask

    initial begin
        reset = 1'b1;
        dl_active = 1'b0;
        dl_wr = 1'b0;
        dl_addr = 25'd0;
        dl_data = 8'd0;
        repeat (3) tick();
        check("rst_rom_wr", 32'(rom_wr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_data", 32'(rom_data), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_load_ok", 32'(load_ok), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_count", 32'(byte_count), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Full image from WAIT, including a write in the rise cycle that must be dropped.
        start_download(1'b1);
        run_download(-1, -1);
        finish_hold("full");
        check("hits_r0", 32'(hits[0]), 32'(R0_END));
        check("hits_r1", 32'(hits[1]), 32'(R1_END - R0_END));
        check("hits_r2", 32'(hits[2]), 32'(R2_END - R1_END));
        check("hits_r3", 32'(hits[3]), 32'(R3_END - R2_END));

        // Reload from RUN with one byte missing.
        start_download(1'b1);
        run_download(int'($urandom_range(R3_END - 1, 0)), -1);
        finish_hold("short");

        // Complete image plus one write past the end, starting from WAIT.
        start_download(1'b0);
        run_download(-1, R3_END);
        finish_hold("extra");

        // Good image, then stray writes while the core runs.
        start_download(1'b0);
        run_download(-1, -1);
        finish_hold("good2");
        for (int i = 0; i < 5; i++) begin
            send_byte(int'($urandom_range(R3_END - 1, 0)), 8'($urandom));
            check("run_core_reset", 32'(core_reset), 32'd0);
        end

        // Async reset in the middle of a download with a strobe in flight.
        start_download(1'b0);
        for (int a = 0; a < 100; a++) send_byte(a, 8'($urandom));
        #2;
        reset = 1'b1;
        #1;
        check("arst_kill_strobe", 32'(rom_wr), 32'd0);
        check("arst_count", 32'(byte_count), 32'd0);
        check("arst_core_reset", 32'(core_reset), 32'd1);
        check("arst_rom_addr", 32'(rom_addr), 32'd0);
        model_loading = 1'b0;
        model_count = 0;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_byte(100 + i, 8'($urandom));
            check("arst_hold_core_reset", 32'(core_reset), 32'd1);
        end
        dl_active = 1'b0;
        repeat (2) tick();
        start_download(1'b0);
        send_byte(R1_END, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
